crc4_ser_tx: RTL
================

CRC4_SER_TX -- requirements
Module: crc4_ser_tx

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_b  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port din  input  8  parallel data word to transmit.
REQ-004 SHALL have port din_vld  input  1  din valid.
REQ-005 SHALL have port din_rdy  output  1  block can accept din this cycle.
REQ-006 SHALL have port sout  output  1  serial bit stream.
REQ-007 SHALL have port sout_vld  output  1  high while sout carries a frame bit.
REQ-008 SHALL have port done  output  1  one-cycle pulse on the last bit of a frame.
REQ-009 SHALL have port err_inj  input  1  CRC corruption request; present only with CRC4_TX_ERRINJ_EN.

Function
REQ-010 SHALL use a 3-state FSM: IDLE, DATA, CRC.
REQ-011 SHALL transfer din when din_vld and din_rdy are high at a rising edge ("accept edge").
REQ-012 SHALL assert din_rdy in IDLE and in the last CRC cycle, and deassert it otherwise.
REQ-013 At accept: SHALL load din into an 8-bit shift register, clear the 4-bit CRC register c[3:0], clear the bit counter, and enter DATA.
REQ-014 SHALL present a frame as 12 cycles after the accept edge: cycles 1-8 carry din[7]..din[0]; cycles 9-12 carry c[3]..c[0].
REQ-015 SHALL hold sout_vld high for all 12 frame cycles and low otherwise.
REQ-016 SHALL assert done only in frame cycle 12.
REQ-017 On each DATA cycle with bit b = sout, SHALL update the CRC at the closing edge: f = b ^ c3; c0 <= f; c1 <= c0 ^ f; c2 <= c1; c3 <= c2 (generator x^4+x+1).
REQ-018 In CRC state, SHALL drive sout = c[3] and shift c left by one, filling with 0, at each edge.
REQ-019 Frame property: a receiver signature register using the same polynomial, cleared before the frame and fed all 12 bits, SHALL end at 4'b0000.
REQ-020 SHALL derive sout, sout_vld, done and din_rdy from registered state only; there is no combinational path from din, din_vld or err_inj to any output.
REQ-021 SHALL force sout = 0 when sout_vld = 0.
REQ-022 Back-to-back: if an accept occurs at the edge closing frame cycle 12, the next cycle SHALL be frame cycle 1 of the new word with no idle gap.
REQ-023 If there is no accept at the end of cycle 12, SHALL return to IDLE.
REQ-024 SHALL ignore din_vld while din_rdy is low; din may change freely after the accept edge.

Reset
REQ-025 With rst_b low at a rising edge, SHALL enter IDLE and clear the shift register, c and the bit counter.
REQ-026 After a reset edge, outputs SHALL be: sout=0, sout_vld=0, done=0, din_rdy=1.
REQ-027 Reset SHALL take priority over an accept in the same cycle.
REQ-028 Reset mid-frame SHALL abort the frame; no remaining bits and no done pulse are emitted.

Configuration
REQ-029 Macro CRC4_TX_ERRINJ_EN defined: SHALL provide port err_inj, sampled at the accept edge into an internal flag.
REQ-030 When that flag is set, SHALL invert sout in frame cycle 12 (c[0]); the flag clears at the next accept or reset.
REQ-031 Macro CRC4_TX_ERRINJ_EN undefined: SHALL omit the err_inj port and flag logic; frames are always correct.

Verification
REQ-032 Reset with din_vld=0 -> sout=0, sout_vld=0, done=0, din_rdy=1.
REQ-033 Send din=8'h80 -> sout = 1,0,0,0,0,0,0,0 then 1,1,1,0 (CRC 4'hE); done only in cycle 12.
REQ-034 Send din=8'hFF then 8'h00 back-to-back -> 1x8, then 0,1,0,0 (CRC 4'h4), then immediately 0x8, then 0,0,0,0; no gap; two done pulses.
REQ-035 Random words through a bench receiver signature model -> residue 4'b0000 every frame; with err_inj=1 at accept (macro on) -> residue nonzero, last bit flipped.
REQ-036 rst_b low in frame cycle 5 of din=8'hA5 -> next cycle is IDLE, din_rdy=1, no done pulse; a following din=8'h80 frame matches REQ-033.

Source files
------------

// File: rtl/crc4_ser_tx.sv
// Serial transmitter: an 8-bit word followed by its CRC-4 (x^4+x+1), MSB first.
// Optional CRC corruption for receiver testing is enabled by defining CRC4_TX_ERRINJ_EN.
module crc4_ser_tx (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       din_rdy,
`ifdef CRC4_TX_ERRINJ_EN
    input  logic       err_inj,
`endif
    output logic       sout,
    output logic       sout_vld,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic [3:0]  crc_reg, crc_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        flag_reg, flag_next;
    logic        last_crc;
    logic        accept;
    logic        inj_req;
    logic        fb;

`ifdef CRC4_TX_ERRINJ_EN
    assign inj_req = err_inj;
`else
    assign inj_req = 1'b0;
`endif

    // Outputs depend on registered state only.
    assign last_crc = (state_reg == CRC) && (cnt_reg == 3'd3);
    assign din_rdy  = (state_reg == IDLE) || last_crc;
    assign sout_vld = (state_reg != IDLE);
    assign done     = last_crc;
    assign accept   = din_vld && din_rdy;
    assign fb       = shift_reg[7] ^ crc_reg[3];

    always_comb begin
        sout = 1'b0;
        case (state_reg)
            DATA:    sout = shift_reg[7];
            CRC:     sout = crc_reg[3] ^ (flag_reg && last_crc);
            default: sout = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        crc_next   = crc_reg;
        cnt_next   = cnt_reg;
        flag_next  = flag_reg;
        case (state_reg)
            DATA: begin
                shift_next = {shift_reg[6:0], 1'b0};
                crc_next   = {crc_reg[2:1], crc_reg[0] ^ fb, fb};
                cnt_next   = cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    state_next = CRC;
                end
            end
            CRC: begin
                crc_next = {crc_reg[2:0], 1'b0};
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == 3'd3) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // An accept in the last CRC cycle overrides the return to IDLE.
        if (accept) begin
            state_next = DATA;
            shift_next = din;
            crc_next   = 4'd0;
            cnt_next   = 3'd0;
            flag_next  = inj_req;
        end
    end

`ifndef CRC4_TX_ERRINJ_EN
    // Without error injection the flag is tied low and never set.
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_reg <= IDLE;
            shift_reg <= 8'd0;
            crc_reg   <= 4'd0;
            cnt_reg   <= 3'd0;
            flag_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            crc_reg   <= crc_next;
            cnt_reg   <= cnt_next;
            flag_reg  <= flag_next;
        end
    end

endmodule
